// File: rtl/frame_capture_pkg.sv
// Shared constants and state encoding for the 160x120 RGB444 frame buffer.
// Used by both the capture writer and the colour analyzer.
package frame_capture_pkg;

  localparam int FRAME_W    = 160;
  localparam int FRAME_H    = 120;
  localparam int NUM_PIXELS = FRAME_W * FRAME_H;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 12;
  localparam int COL_W      = $clog2(FRAME_W);

  // Colour-bar boundaries: thirds of the line, rounded up (54 and 107 for 160 columns).
  localparam int BAR1_END = (FRAME_W + 2) / 3;
  localparam int BAR2_END = (2 * FRAME_W + 2) / 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [11:0] bar_colour(input logic [COL_W-1:0] x);
    if (x < COL_W'(BAR1_END)) return 12'hF00;
    else if (x < COL_W'(BAR2_END)) return 12'h0F0;
    else return 12'h00F;
  endfunction

endpackage

// File: rtl/frame_capture_cam_sync.sv
// Brings the asynchronous camera bus into the clk domain (two flops per signal)
// and derives pclk rising and vsync rising/falling edge strobes.
module frame_capture_cam_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pclk,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_pclk_rise,
  output logic       o_vsync_rise,
  output logic       o_vsync_fall,
  output logic       o_href,
  output logic [7:0] o_data
);

  logic [1:0] r_pclk_sync;
  logic [1:0] r_vsync_sync;
  logic [1:0] r_href_sync;
  logic [7:0] r_data_meta;
  logic [7:0] r_data_sync;
  logic       r_pclk_prev;
  logic       r_vsync_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pclk_sync  <= '0;
      r_vsync_sync <= '0;
      r_href_sync  <= '0;
      r_data_meta  <= '0;
      r_data_sync  <= '0;
      r_pclk_prev  <= 1'b0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_pclk_sync  <= {r_pclk_sync[0], i_pclk};
      r_vsync_sync <= {r_vsync_sync[0], i_vsync};
      r_href_sync  <= {r_href_sync[0], i_href};
      r_data_meta  <= i_data;
      r_data_sync  <= r_data_meta;
      r_pclk_prev  <= r_pclk_sync[1];
      r_vsync_prev <= r_vsync_sync[1];
    end
  end

  // Data travels through the same two-flop depth as pclk, so it is stable at every pclk_rise.
  assign o_pclk_rise  = r_pclk_sync[1] & ~r_pclk_prev;
  assign o_vsync_rise = r_vsync_sync[1] & ~r_vsync_prev;
  assign o_vsync_fall = ~r_vsync_sync[1] & r_vsync_prev;
  assign o_href       = r_href_sync[1];
  assign o_data       = r_data_sync;

endmodule

// File: rtl/frame_capture.sv
// OV7670 RGB444 frame writer: packs byte pairs into 12-bit pixels at addresses 0..NUM_PIXELS-1.
// Define FRAME_CAPTURE_TEST_PATTERN_EN to replace the camera path with a vertical colour-bar generator.
module frame_capture #(
  parameter int NUM_PIXELS = frame_capture_pkg::NUM_PIXELS,
  parameter int ADDR_W     = frame_capture_pkg::ADDR_W,
  parameter int DATA_W     = frame_capture_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_cam_pclk,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  import frame_capture_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t              r_state;
  logic                r_init_prev;
  logic                r_wr_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_we;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_init_rise;
  logic                w_frame_start;
  logic                w_frame_short;
  logic                w_pix_ready;
  logic [DATA_W-1:0]   w_pix;

  assign w_init_rise = i_init & ~r_init_prev;

`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  localparam state_t ARM_STATE = CAPTURE;

  logic [1:0]       r_div;
  logic [COL_W-1:0] r_col;

  // One pixel every 4 clk; the column tracks addr mod FRAME_W without a divider.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_init_rise) begin
      r_div <= '0;
      r_col <= '0;
    end else if (r_state == CAPTURE) begin
      r_div <= r_div + 2'd1;
      if (r_we) r_col <= (r_col == COL_W'(FRAME_W - 1)) ? '0 : r_col + COL_W'(1);
    end
  end

  assign w_pix_ready   = (r_state == CAPTURE) && (r_div == 2'd3);
  assign w_pix         = DATA_W'(bar_colour(r_col));
  assign w_frame_start = 1'b0;
  assign w_frame_short = 1'b0;
`else
  localparam state_t ARM_STATE = WAIT_VS;

  logic       w_pclk_rise;
  logic       w_vsync_rise;
  logic       w_vsync_fall;
  logic       w_href;
  logic [7:0] w_cam_data;
  logic       r_phase;
  logic [3:0] r_red;

  frame_capture_cam_sync u_cam_sync (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pclk       (i_cam_pclk),
    .i_vsync      (i_cam_vsync),
    .i_href       (i_cam_href),
    .i_data       (i_cam_data),
    .o_pclk_rise  (w_pclk_rise),
    .o_vsync_rise (w_vsync_rise),
    .o_vsync_fall (w_vsync_fall),
    .o_href       (w_href),
    .o_data       (w_cam_data)
  );

  // Byte phase: first byte of a pair carries R in its low nibble; href low drops a dangling byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_init_rise) begin
      r_phase <= 1'b0;
      r_red   <= '0;
    end else if (r_state != CAPTURE || !w_href) begin
      r_phase <= 1'b0;
    end else if (w_pclk_rise) begin
      if (!r_phase) r_red <= w_cam_data[3:0];
      r_phase <= ~r_phase;
    end
  end

  assign w_pix_ready   = (r_state == CAPTURE) && w_href && w_pclk_rise && r_phase;
  assign w_pix         = DATA_W'({r_red, w_cam_data});
  assign w_frame_start = w_vsync_fall;
  assign w_frame_short = w_vsync_rise;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_init_prev <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_init_prev <= i_init;
      r_we        <= 1'b0;
      r_wr_pend   <= 1'b0;
      if (w_init_rise) begin
        r_state <= ARM_STATE;
        r_addr  <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          WAIT_VS: begin
            if (w_frame_start) r_state <= CAPTURE;
          end
          CAPTURE: begin
            // A completing last write wins over a coincident vsync rise.
            if (r_we && r_addr == LAST_ADDR) begin
              r_state <= DONE;
              r_addr  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= 1'b0;
            end else if (w_frame_short) begin
              r_state <= DONE;
              r_addr  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_we <= r_wr_pend;
              if (r_we) r_addr <= r_addr + ADDR_W'(1);
              if (w_pix_ready) begin
                r_data    <= w_pix;
                r_wr_pend <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_we   = r_we;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: scenario table of camera frames with random pixel bytes,
// scoreboarded against a byte-pair model, plus odd-byte, re-arm and reset sequences.
`timescale 1ns/1ps
module tb_frame_capture;

`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  localparam int NPIX = 192;
`else
  localparam int NPIX = 96;
`endif
  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          pclk = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we, busy, done, err;

  frame_capture #(.NUM_PIXELS(NPIX), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init),
    .i_cam_pclk(pclk), .i_cam_vsync(vsync), .i_cam_href(href), .i_cam_data(cam_data),
    .o_addr(addr), .o_data(data), .o_we(we), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct {
    int lines; int bpl; bit fixed; bit do_arm; int rearm_after;
    int exp_writes; bit exp_done; bit exp_err;
  } row_t;

  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];
  logic [7:0] line_q[$];
  int   m_count = 0;
  bit   armed = 1'b0;
  int   writes_seen = 0;
  int   cyc = 0;
  int   last_we_cyc = -1;
  int   done_rise_cyc = -1;
  logic prev_done = 1'b0;
  logic prev_we = 1'b0;
  row_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every we pulse must match the head of the model queue.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done = done;
      if (we) begin
        writes_seen++;
        if (addr == AW'(NPIX - 1)) last_we_cyc = cyc;
        check("we_one_cycle", 32'(prev_we), 32'(0));
        check("busy_while_writing", 32'(busy), 32'(1));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_we: addr %0d data %0h, no write expected", addr, data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(addr), 32'(e.a));
          check("wr_data", 32'(data), 32'(e.d));
        end
      end
      prev_we = we;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int h;
    h = $urandom_range(2, 3);
    cam_data = b;
    repeat (h) @(negedge clk);
    pclk = 1'b1;
    repeat (h) @(negedge clk);
    pclk = 1'b0;
  endtask

  // Model: pixels are consecutive byte pairs within one line, addressed in arrival order.
  task automatic send_line(input bit track);
    logic [7:0] b0;
    b0 = 8'h00;
    href = 1'b1;
    for (int i = 0; i < line_q.size(); i++) begin
      if (i % 2 == 0) b0 = line_q[i];
      else if (track && m_count < NPIX) begin
        exp_q.push_back('{a: AW'(m_count), d: {b0[3:0], line_q[i]}});
        m_count++;
      end
      send_byte(line_q[i]);
    end
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic fill_line(input int nbytes, input bit fixed);
    line_q.delete();
    for (int i = 0; i < nbytes; i++)
      line_q.push_back(fixed ? ((i % 2 == 1) ? 8'hBC : 8'h0A) : 8'($urandom));
  endtask

  task automatic arm();
    init = 1'b1;
    @(negedge clk);
    check("arm_busy", 32'(busy), 32'(1));
    check("arm_done", 32'(done), 32'(0));
    check("arm_err", 32'(err), 32'(0));
    check("arm_addr", 32'(addr), 32'(0));
    init = 1'b0;
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame();
    m_count = 0;
    writes_seen = 0;
    last_we_cyc = -1;
    done_rise_cyc = -1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bit tracking;
    // Reset with init toggling
    for (int i = 0; i < 3; i++) begin
      init = ~init;
      @(negedge clk);
    end
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_data", 32'(data), 32'(0));
    check("rst_we", 32'(we), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_done", 32'(done), 32'(0));

`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    writes_seen = 0;
    last_we_cyc = -1;
    done_rise_cyc = -1;
    for (int a = 0; a < NPIX; a++) begin
      int x;
      logic [11:0] c;
      x = a % 160;
      c = (x <= 53) ? 12'hF00 : ((x <= 106) ? 12'h0F0 : 12'h00F);
      exp_q.push_back('{a: AW'(a), d: c});
    end
    arm();
    for (int k = 0; k < 4 * NPIX + 40 && !done; k++) @(negedge clk);
    check("pat_done", 32'(done), 32'(1));
    check("pat_err", 32'(err), 32'(0));
    check("pat_busy", 32'(busy), 32'(0));
    check("pat_addr", 32'(addr), 32'(0));
    check("pat_writes", 32'(writes_seen), 32'(NPIX));
    check("pat_drain", 32'(exp_q.size()), 32'(0));
    check("pat_done_latency", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
`else
    //             lines bpl fixed arm rearm writes done err
    tbl[0] = '{8,  24, 1'b1, 1'b1, 0, 96, 1'b1, 1'b0};  // full frame of 0x0A,0xBC
    tbl[1] = '{3,  24, 1'b0, 1'b1, 0, 36, 1'b1, 1'b1};  // short frame
    tbl[2] = '{8,  24, 1'b0, 1'b0, 0, 0,  1'b1, 1'b1};  // not armed: done/err held
    tbl[3] = '{8,  25, 1'b0, 1'b1, 0, 96, 1'b1, 1'b0};  // trailing odd byte per line
    tbl[4] = '{10, 24, 1'b0, 1'b1, 0, 96, 1'b1, 1'b0};  // extra lines ignored
    tbl[5] = '{8,  24, 1'b0, 1'b1, 2, 24, 1'b0, 1'b0};  // re-arm mid-capture
    tbl[6] = '{8,  24, 1'b0, 1'b0, 0, 96, 1'b1, 1'b0};  // frame after re-arm
    tbl[7] = '{5,  23, 1'b0, 1'b1, 0, 55, 1'b1, 1'b1};  // short frame, odd lines

    for (int r = 0; r < 8; r++) begin
      if (tbl[r].do_arm) arm();
      tracking = armed;
      start_frame();
      for (int l = 0; l < tbl[r].lines; l++) begin
        fill_line(tbl[r].bpl, tbl[r].fixed);
        send_line(tracking);
        if (l + 1 == tbl[r].rearm_after) begin
          check("rearm_drain", 32'(exp_q.size()), 32'(0));
          arm();
          tracking = 1'b0;
        end
      end
      if (tracking) armed = 1'b0;
      end_frame();
      check($sformatf("row%0d_writes", r), 32'(writes_seen), 32'(tbl[r].exp_writes));
      check($sformatf("row%0d_done", r), 32'(done), 32'(tbl[r].exp_done));
      check($sformatf("row%0d_busy", r), 32'(busy), 32'(!tbl[r].exp_done));
      check($sformatf("row%0d_addr", r), 32'(addr), 32'(0));
      check($sformatf("row%0d_drain", r), 32'(exp_q.size()), 32'(0));
      if (tbl[r].exp_done) check($sformatf("row%0d_err", r), 32'(err), 32'(tbl[r].exp_err));
      if (tbl[r].exp_done && !tbl[r].exp_err && tbl[r].exp_writes == NPIX)
        check($sformatf("row%0d_done_latency", r), 32'(done_rise_cyc), 32'(last_we_cyc + 1));
    end

    // Odd byte then next line: phase must restart, so 0x5A is R of the next pixel.
    arm();
    start_frame();
    line_q = '{8'h01, 8'h23, 8'h04};
    send_line(1'b1);
    line_q = '{8'h5A, 8'h67};
    send_line(1'b1);
    armed = 1'b0;
    end_frame();
    check("odd_writes", 32'(writes_seen), 32'(2));
    check("odd_done", 32'(done), 32'(1));
    check("odd_err", 32'(err), 32'(1));
    check("odd_drain", 32'(exp_q.size()), 32'(0));

    // Reset mid-capture aborts the frame; nothing further is written.
    arm();
    start_frame();
    fill_line(24, 1'b0);
    send_line(1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_addr", 32'(addr), 32'(0));
    check("midrst_we", 32'(we), 32'(0));
    rst_n = 1'b1;
    armed = 1'b0;
    fill_line(24, 1'b0);
    send_line(1'b0);
    end_frame();
    check("midrst_writes", 32'(writes_seen), 32'(12));
    check("midrst_idle_done", 32'(done), 32'(0));
    check("midrst_idle_busy", 32'(busy), 32'(0));
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
